// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 width, arbiter FSM states and index-width helper
package fp16_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A single requester still needs one index bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter
    import fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic           found;
    int             cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand     = (int'(rr_ptr) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req_valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/fp16_mult_arbiter.sv
// rtl/fp16_mult_arbiter.sv - round-robin sharing of one FP16 multiplier across MAC lanes
module fp16_mult_arbiter
    import fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = FP16_W,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         mult_a,
    output logic [W-1:0]         mult_b,
    input  logic [W-1:0]         mult_p,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               complete;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept   = (state_q == ST_IDLE) && (|req_valid);
    assign complete = (state_q == ST_RESP) && rsp_ready[owner];
    assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign busy     = (state_q != ST_IDLE);
    assign op_count = cnt_q;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                // Grant is masked during reset so every output reads zero at once.
                if (!reset) req_ready = grant;
                if (accept) state_d = ST_MULT;
            end
            ST_MULT: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (complete) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            rsp_data <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mult_a <= req_a[grant_idx*W +: W];
                mult_b <= req_b[grant_idx*W +: W];
                owner  <= grant_idx;
                rr_ptr <= next_ptr;
            end
            // The shared multiplier settles within the MULT cycle.
            if (state_q == ST_MULT) rsp_data <= mult_p;
            if (complete) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// tb/tb_fp16_mult_arbiter.sv - directed self-checking bench for fp16_mult_arbiter
module tb_fp16_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [15:0] mult_p;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        busy;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    fp16_mult_arbiter #(.NUM_REQ(4), .W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    assign mult_p = mult_a + mult_b;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int lane, input logic [15:0] a, input logic [15:0] b);
        req_a[lane*16 +: 16] = a;
        req_b[lane*16 +: 16] = b;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        tick();
        tick();
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_op_count", op_count, 16'h0);
        chk("rst_mult_a", mult_a, 16'h0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        reset = 1'b0;

        // All lanes valid: grants 0,1,2,3,0, one op per 3 cycles
        for (int i = 0; i < 4; i++) set_ops(i, 16'(16'h0100 * (i + 1)), 16'(16'h0010 * (i + 1)));
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_grant%0d", k), 16'(req_ready), 16'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_mult_ready%0d", k), 16'(req_ready), 16'h0);
            tick();
            chk($sformatf("rr_rsp_valid%0d", k), 16'(rsp_valid), 16'(4'b0001 << (k % 4)));
            chk($sformatf("rr_rsp_data%0d", k), rsp_data, 16'(16'h0110 * ((k % 4) + 1)));
            tick();
        end
        req_valid = '0;
        chk("rr_op_count", op_count, 16'd5);

        // Single op on lane 2: 3C00 + 4000 through the adder stub
        set_ops(2, 16'h3C00, 16'h4000);
        req_valid = 4'b0100;
        rsp_ready = 4'b0100;
        #1;
        chk("s_req_ready", 16'(req_ready), 16'h0004);
        tick();
        req_valid = '0;
        chk("s_busy", 16'(busy), 16'h1);
        chk("s_mult_a", mult_a, 16'h3C00);
        chk("s_mult_b", mult_b, 16'h4000);
        tick();
        chk("s_rsp_valid", 16'(rsp_valid), 16'h0004);
        chk("s_rsp_data", rsp_data, 16'h7C00);
        tick();
        chk("s_op_count", op_count, 16'd6);
        chk("s_idle", 16'(busy), 16'h0);

        // Stall: rr_ptr=3 so lane 0 wins over lane 1; lane 1 stays pending
        set_ops(0, 16'h1000, 16'h0234);
        set_ops(1, 16'h0505, 16'h0101);
        req_valid = 4'b0011;
        rsp_ready = 4'b0000;
        #1;
        chk("st_grant", 16'(req_ready), 16'h0001);
        tick();
        req_valid = 4'b0010;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("st_valid%0d", k), 16'(rsp_valid), 16'h0001);
            chk($sformatf("st_data%0d", k), rsp_data, 16'h1234);
            chk($sformatf("st_noready%0d", k), 16'(req_ready), 16'h0);
            tick();
        end
        rsp_ready = 4'b0001;
        #1;
        chk("st_6th_valid", 16'(rsp_valid), 16'h0001);
        tick();
        req_valid = '0;
        #1;
        chk("st_done_count", op_count, 16'd7);
        chk("st_done_valid", 16'(rsp_valid), 16'h0);

        // Wrong-lane ack: rr_ptr=1, only lane 3 requests
        set_ops(3, 16'h0003, 16'h0004);
        req_valid = 4'b1000;
        rsp_ready = 4'b0001;
        #1;
        chk("wl_grant", 16'(req_ready), 16'h0008);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("wl_hold_valid", 16'(rsp_valid), 16'h0008);
        chk("wl_hold_count", op_count, 16'd7);
        chk("wl_data", rsp_data, 16'h0007);
        rsp_ready = 4'b1000;
        tick();
        chk("wl_done_count", op_count, 16'd8);

        // Reset during MULT: rr_ptr=0 afterwards so lane 1 beats lane 3
        req_valid = 4'b0010;
        rsp_ready = 4'b0010;
        #1;
        chk("ra_grant", 16'(req_ready), 16'h0002);
        tick();
        req_valid = 4'b1010;
        chk("ra_busy", 16'(busy), 16'h1);
        reset = 1'b1;
        #1;
        chk("ra_busy_rst", 16'(busy), 16'h0);
        chk("ra_ready_rst", 16'(req_ready), 16'h0);
        chk("ra_mult_a_rst", mult_a, 16'h0);
        chk("ra_count_rst", op_count, 16'h0);
        chk("ra_data_rst", rsp_data, 16'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("ra_regrant", 16'(req_ready), 16'h0002);
        tick();
        req_valid = '0;
        tick();
        chk("ra_rsp_data", rsp_data, 16'h0606);
        tick();
        chk("ra_count", op_count, 16'd1);

        // Counter wrap from FFFF
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("wr_preset", op_count, 16'hFFFF);
        req_valid = 4'b0010;
        rsp_ready = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("wr_wrap", op_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
